debounce_multi: RTL and testbench

Parametrised N-channel push-button/switch debouncer, the successor to the single-channel fixed-16-bit debouncer.
- Synchronises each raw asynchronous input into the clk domain.
- Debounces against a run-time programmable threshold.
- Provides level, press/release pulses and a long-press detect per channel.
- Sits between board buttons/DIP switches and the control/register logic of the SDR TX design.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_multi_if.sv | 26 ++
 rtl/debounce_chan.sv | 69 ++++++
 rtl/debounce_multi.sv | 45 ++++
 tb/tb_debounce_multi.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types, limits and parameter checks for the debounce_multi block
// Provides the synchroniser depth range check and the per-channel state record.
package debounce_pkg;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
    // State record counters are sized for the widest legal counter; channels mask down to their width.
    localparam int CTR_W = 32;

    function automatic bit sync_ok(input int stages);
        return stages >= SYNC_MIN && stages <= SYNC_MAX;
    endfunction

    typedef struct packed {
        logic [CTR_W-1:0] cnt;
        logic [CTR_W-1:0] lcnt;
        logic             state;
        logic             held;
    } chan_st_t;
endpackage

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: button inputs, thresholds and debounced outputs of debounce_multi
// master drives pb_in/db_thr/long_thr and observes the outputs; slave is the debouncer.
interface debounce_multi_if #(
    parameter int CH     = 4,
    parameter int CNT_W  = 16,
    parameter int LONG_W = 24
);
    logic [CH-1:0]     pb_in;
    logic [CNT_W-1:0]  db_thr;
    logic [LONG_W-1:0] long_thr;
    logic [CH-1:0]     pb_state;
    logic [CH-1:0]     pb_down;
    logic [CH-1:0]     pb_up;
    logic [CH-1:0]     pb_long;
    logic [CH-1:0]     pb_held;
    logic              any_active;

    modport master (
        output pb_in, db_thr, long_thr,
        input  pb_state, pb_down, pb_up, pb_long, pb_held, any_active
    );
    modport slave (
        input  pb_in, db_thr, long_thr,
        output pb_state, pb_down, pb_up, pb_long, pb_held, any_active
    );
endinterface

// File: rtl/debounce_chan.sv
// debounce_chan: one channel of synchroniser, debounce counter and long-press detector
// Ports: clk, rst (async high); pb_in raw input; db_thr/long_thr thresholds;
// pb_state level, pb_down/pb_up/pb_long pulses, pb_held long-press level.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   CNT_W       = 16,
    parameter int   LONG_W      = 24,
    parameter int   SYNC_STAGES = 2,
    parameter logic ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pb_in,
    input  logic [CNT_W-1:0]  db_thr,
    input  logic [LONG_W-1:0] long_thr,
    output logic              pb_state,
    output logic              pb_down,
    output logic              pb_up,
    output logic              pb_long,
    output logic              pb_held
);
    localparam logic [CTR_W-1:0] CNT_MASK  = CTR_W'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CTR_W-1:0] LONG_MASK = CTR_W'((64'd1 << LONG_W) - 64'd1);
    localparam logic [CTR_W-1:0] ONE       = CTR_W'(1);

    if (!sync_ok(SYNC_STAGES) || CNT_W > CTR_W || LONG_W > CTR_W) begin : g_bad
        $error("debounce_chan: SYNC_STAGES must be 2..4 and counter widths at most 32");
    end

    logic [SYNC_STAGES-1:0] sr;
    chan_st_t               st, nx;
    logic                   sync, diff, fire, long_hit;
    logic [CTR_W-1:0]       thr, lthr;

    always_comb begin
        sync = sr[SYNC_STAGES-1];
        thr  = CTR_W'(db_thr);
        lthr = CTR_W'(long_thr);
        diff = sync != st.state;
        fire = diff && st.cnt >= thr;
        // A release this cycle wins over a long-press hit so pb_long never coincides with pb_up.
        long_hit = st.state && !st.held && !fire && lthr != '0 && st.lcnt == lthr - ONE;
        nx.state = st.state ^ fire;
        nx.cnt   = (diff && !fire) ? (st.cnt + ONE) & CNT_MASK : '0;
        nx.held  = st.state && !fire && (st.held || long_hit);
        nx.lcnt  = (!st.state || fire) ? '0 :
                   (st.held || long_hit) ? st.lcnt : (st.lcnt + ONE) & LONG_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            st      <= '0;
            pb_down <= 1'b0;
            pb_up   <= 1'b0;
            pb_long <= 1'b0;
        end else begin
            sr      <= {sr[SYNC_STAGES-2:0], pb_in ^ ACTIVE_LOW};
            st      <= nx;
            pb_down <= fire && !st.state;
            pb_up   <= fire && st.state;
            pb_long <= long_hit;
        end
    end

    assign pb_state = st.state;
    assign pb_held  = st.held;
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button/switch debouncer with press/release/long-press pulses
// Ports: clk, rst (async high); bus (slave) carries pb_in, db_thr, long_thr and
// pb_state, pb_down, pb_up, pb_long, pb_held, any_active.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int            CH          = 4,
    parameter int            CNT_W       = 16,
    parameter int            LONG_W      = 24,
    parameter logic [CH-1:0] ACTIVE_LOW  = {CH{1'b1}},
    parameter int            SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    debounce_multi_if.slave  bus
);
    logic [CH-1:0] state, down, up, lng, held;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        debounce_chan #(
            .CNT_W      (CNT_W),
            .LONG_W     (LONG_W),
            .SYNC_STAGES(SYNC_STAGES),
            .ACTIVE_LOW (ACTIVE_LOW[c])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .pb_in   (bus.pb_in[c]),
            .db_thr  (bus.db_thr),
            .long_thr(bus.long_thr),
            .pb_state(state[c]),
            .pb_down (down[c]),
            .pb_up   (up[c]),
            .pb_long (lng[c]),
            .pb_held (held[c])
        );
    end

    assign bus.pb_state   = state;
    assign bus.pb_down    = down;
    assign bus.pb_up      = up;
    assign bus.pb_long    = lng;
    assign bus.pb_held    = held;
    assign bus.any_active = |state;
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed self-checking bench for debounce_multi
module tb_debounce_multi;
    localparam int            CH     = 4;
    localparam int            CNT_W  = 16;
    localparam int            LONG_W = 24;
    localparam logic [CH-1:0] AL     = 4'b0111;
    localparam logic [CH-1:0] IDLE   = 4'b0111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debounce_multi_if #(.CH(CH), .CNT_W(CNT_W), .LONG_W(LONG_W)) bus ();

    debounce_multi #(
        .CH(CH), .CNT_W(CNT_W), .LONG_W(LONG_W), .ACTIVE_LOW(AL), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int d_at[CH], u_at[CH], l_at[CH], h_at[CH], d_n[CH], u_n[CH], l_n[CH];
    int ex_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int c = 0; c < CH; c++) begin
            d_at[c] = -1; u_at[c] = -1; l_at[c] = -1; h_at[c] = -1;
            d_n[c] = 0; u_n[c] = 0; l_n[c] = 0;
        end
        ex_n = 0;
    endtask

    // Advance n edges, recording the first edge (counted from the call) of each event per channel.
    task automatic run(input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            for (int c = 0; c < CH; c++) begin
                if (bus.pb_down[c]) begin d_n[c]++; if (d_at[c] < 0) d_at[c] = k; end
                if (bus.pb_up[c])   begin u_n[c]++; if (u_at[c] < 0) u_at[c] = k; end
                if (bus.pb_long[c]) begin l_n[c]++; if (l_at[c] < 0) l_at[c] = k; end
                if (bus.pb_held[c] && h_at[c] < 0) h_at[c] = k;
                if (int'(bus.pb_down[c]) + int'(bus.pb_up[c]) + int'(bus.pb_long[c]) > 1) ex_n++;
            end
        end
    endtask

    initial begin
        int tot;
        bus.pb_in    = IDLE;
        bus.db_thr   = 16'd10;
        bus.long_thr = 24'd0;
        clr();
        repeat (3) tick();
        check("rst_state", 32'(bus.pb_state), 0);
        check("rst_down",  32'(bus.pb_down), 0);
        check("rst_up",    32'(bus.pb_up), 0);
        check("rst_long",  32'(bus.pb_long), 0);
        check("rst_held",  32'(bus.pb_held), 0);
        check("rst_any",   32'(bus.any_active), 0);
        rst = 1'b0;

        // idle inputs for 100 cycles
        clr();
        run(100);
        tot = 0;
        for (int c = 0; c < CH; c++) tot += d_n[c] + u_n[c] + l_n[c];
        check("idle_pulses", 32'(tot), 0);
        check("idle_state", 32'(bus.pb_state), 0);
        check("idle_any", 32'(bus.any_active), 0);

        // clean press and release on ch0
        bus.pb_in[0] = 1'b0;
        clr();
        run(20);
        check("press0_at", 32'(d_at[0]), 13);
        check("press0_n", 32'(d_n[0]), 1);
        check("press0_others", 32'(d_n[1] + d_n[2] + d_n[3]), 0);
        check("press0_state", 32'(bus.pb_state), 32'b0001);
        check("press0_any", 32'(bus.any_active), 1);
        bus.pb_in[0] = 1'b1;
        clr();
        run(20);
        check("rel0_at", 32'(u_at[0]), 13);
        check("rel0_n", 32'(u_n[0]), 1);
        check("rel0_any", 32'(bus.any_active), 0);

        // bounce on ch1, then stable low
        clr();
        for (int j = 0; j < 10; j++) begin
            bus.pb_in[1] = ~bus.pb_in[1];
            run(5);
        end
        check("bounce_pulses", 32'(d_n[1] + u_n[1]), 0);
        check("bounce_state", 32'(bus.pb_state), 0);
        bus.pb_in[1] = 1'b0;
        clr();
        run(20);
        check("bounce_press_at", 32'(d_at[1]), 13);
        check("bounce_press_n", 32'(d_n[1]), 1);
        bus.pb_in[1] = 1'b1;
        run(20);

        // long press on ch2
        bus.db_thr   = 16'd4;
        bus.long_thr = 24'd100;
        bus.pb_in[2] = 1'b0;
        clr();
        run(300);
        check("long_down_at", 32'(d_at[2]), 7);
        check("long_at", 32'(l_at[2]), 107);
        check("long_held_at", 32'(h_at[2]), 107);
        check("long_n", 32'(l_n[2]), 1);
        check("long_held", 32'(bus.pb_held[2]), 1);
        check("long_excl", 32'(ex_n), 0);
        bus.pb_in[2] = 1'b1;
        clr();
        run(50);
        check("long_up_at", 32'(u_at[2]), 7);
        check("long_no_second", 32'(l_n[2]), 0);
        check("long_held_clr", 32'(bus.pb_held[2]), 0);

        // simultaneous press on ch0 (active low) and ch3 (active high)
        bus.db_thr   = 16'd10;
        bus.long_thr = 24'd0;
        bus.pb_in    = 4'b1110;
        clr();
        run(20);
        check("sim_down0_at", 32'(d_at[0]), 13);
        check("sim_down3_at", 32'(d_at[3]), 13);
        check("sim_state", 32'(bus.pb_state), 32'b1001);
        check("sim_any", 32'(bus.any_active), 1);
        bus.pb_in = IDLE;
        clr();
        run(20);
        check("sim_up0_at", 32'(u_at[0]), 13);
        check("sim_up3_at", 32'(u_at[3]), 13);
        check("sim_idle_any", 32'(bus.any_active), 0);

        // reset mid-count, button held through release, long_thr = 0
        bus.pb_in[0] = 1'b0;
        clr();
        run(9);
        #2 rst = 1'b1;
        #1 check("rstcnt_state", 32'(bus.pb_state), 0);
        tick();
        tick();
        rst = 1'b0;
        clr();
        run(120);
        check("rstcnt_down_at", 32'(d_at[0]), 13);
        check("rstcnt_no_long", 32'(l_n[0]), 0);
        check("rstcnt_no_held", 32'(bus.pb_held[0]), 0);

        // reset mid-hold with long_thr = 5
        bus.pb_in[0] = 1'b1;
        run(20);
        bus.long_thr = 24'd5;
        bus.pb_in[0] = 1'b0;
        clr();
        run(30);
        check("hold_down_at", 32'(d_at[0]), 13);
        check("hold_long_at", 32'(l_at[0]), 18);
        check("hold_held", 32'(bus.pb_held[0]), 1);
        #3 rst = 1'b1;
        #1;
        check("rsthold_state", 32'(bus.pb_state), 0);
        check("rsthold_held", 32'(bus.pb_held), 0);
        check("rsthold_any", 32'(bus.any_active), 0);
        tick();
        tick();
        rst = 1'b0;
        clr();
        run(30);
        check("rsthold_down_at", 32'(d_at[0]), 13);
        check("rsthold_long_at", 32'(l_at[0]), 18);
        check("rsthold_excl", 32'(ex_n), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
